// File: rtl/motor_cmd_ctrl_if.sv
// Command and pulse-generator bundle for motor_cmd_ctrl.
// slave  : the controller (consumes commands and busy, drives start, move outputs and strobes).
// master : the surrounding logic (command decoder and pulse generator together).
//   cmd_valid/cmd_ready/cmd_motor/cmd_bcd : one BCD absolute-target command per handshake
//   busy/start/motor_out/pulse_num/dir_out : move issue towards the pulse generator
//   done/err                              : one-cycle completion / rejection strobes
interface motor_cmd_ctrl_if #(
  parameter int CH     = 6,
  parameter int DIGITS = 3,
  parameter int PNW    = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [CH-1:0]         cmd_motor;
  logic [4*DIGITS-1:0]   cmd_bcd;
  logic                  busy;
  logic                  start;
  logic [CH-1:0]         motor_out;
  logic [PNW-1:0]        pulse_num;
  logic [CH-1:0]         dir_out;
  logic                  done;
  logic                  err;

  modport master (
    output cmd_valid, cmd_motor, cmd_bcd, busy,
    input  cmd_ready, start, motor_out, pulse_num, dir_out, done, err
  );

  modport slave (
    input  cmd_valid, cmd_motor, cmd_bcd, busy,
    output cmd_ready, start, motor_out, pulse_num, dir_out, done, err
  );
endinterface

// File: rtl/motor_cmd_ctrl.sv
// Multi-axis move controller: BCD absolute target -> binary, homing/limit check, pulse count + direction.
// Latency: accept at edge k, err/zero-move done after edge k+DIGITS+1, earliest start after edge k+DIGITS+2.
// Backpressure: one command in flight; cmd_ready low from accept until back in IDLE; start waits for busy=0.
// Ports:
//   sysclk, rst (async, active-low), init (sync clear)
//   home_done[CH]  per-channel homing complete
//   bus            motor_cmd_ctrl_if.slave (command handshake, busy/start, move outputs, done/err)
//   pos_sel/pos_rd combinational readback of a stored channel position
// CH must be at least 2 so the channel index has a non-zero width.
module motor_cmd_ctrl #(
  parameter int CH      = 6,
  parameter int DIGITS  = 3,
  parameter int PW      = 10,
  parameter int MAX_POS = 999,
  parameter int PPU     = 1,
  parameter int PNW     = 16
) (
  input  logic                    sysclk,
  input  logic                    rst,
  input  logic                    init,
  input  logic [CH-1:0]           home_done,
  motor_cmd_ctrl_if.slave         bus,
  input  logic [$clog2(CH)-1:0]   pos_sel,
  output logic [PW-1:0]           pos_rd
);

  // Four spare bits keep acc*10+digit exact for any DIGITS-digit input that
  // could still pass the limit check, so acc > MAX_POS is never fooled by wrap.
  localparam int AW  = PW + 4;
  localparam int CW  = $clog2(CH);
  localparam int DCW = $clog2(DIGITS + 1);
  localparam logic [AW-1:0] MAXP = AW'(MAX_POS);

  typedef enum logic [2:0] {IDLE, CONV, CHECK, ISSUE, ACK, WAIT} state_t;

  state_t               state, state_n;

  logic [CH-1:0]        motor_q;
  logic [4*DIGITS-1:0]  bcd_q;
  logic [AW-1:0]        acc;
  logic                 bad;
  logic [DCW-1:0]       dcnt;
  logic [PW-1:0]        dist_q;
  logic                 dir_q;
  logic [PW-1:0]        pos [CH];

  logic [3:0]           digit;
  logic [AW-1:0]        acc_next;
  logic                 last_digit;
  logic [CW-1:0]        ch_idx;
  logic [PW-1:0]        pos_cur;
  logic [PW-1:0]        acc_pw;
  logic [PW-1:0]        dist_c;
  logic                 reject;

  logic                 accept;
  logic                 do_issue;
  logic                 ready_n;
  logic                 start_n;
  logic                 done_n;
  logic                 err_n;

  // Digits are consumed from the top nibble; bcd_q shifts left one nibble per CONV cycle.
  assign digit      = bcd_q[4*DIGITS-1 -: 4];
  assign acc_next   = (acc << 3) + (acc << 1) + AW'(digit);
  assign last_digit = (dcnt == DCW'(DIGITS - 1));

  // One-hot to index; only meaningful when motor_q is one-hot, which the
  // reject test guarantees before the index is used to touch any state.
  always_comb begin
    ch_idx = '0;
    for (int i = 0; i < CH; i++) begin
      if (motor_q[i]) ch_idx = CW'(i);
    end
  end

  assign pos_cur = pos[ch_idx];
  assign acc_pw  = acc[PW-1:0];
  assign dist_c  = (acc_pw >= pos_cur) ? (acc_pw - pos_cur) : (pos_cur - acc_pw);

  assign reject = bad
               || !$onehot(motor_q)
               || !home_done[ch_idx]
               || (acc > MAXP);

  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    do_issue = 1'b0;
    start_n  = 1'b0;
    done_n   = 1'b0;
    err_n    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cmd_valid && bus.cmd_ready) begin
          accept  = 1'b1;
          state_n = CONV;
        end
      end
      CONV: begin
        if (last_digit) state_n = CHECK;
      end
      CHECK: begin
        if (reject) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else if (acc_pw == pos_cur) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (!bus.busy) begin
          start_n  = 1'b1;
          do_issue = 1'b1;
          state_n  = ACK;
        end
      end
      // busy is ignored here: the pulse generator gets one cycle to raise it.
      ACK: state_n = WAIT;
      WAIT: begin
        if (!bus.busy) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // Registered ready tracks the state we are heading into, so it rises on
    // the same edge as done/err and the next accept can follow one cycle later.
    ready_n = (state_n == IDLE);
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      bus.cmd_ready <= 1'b0;
      bus.start     <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.motor_out <= '0;
      bus.pulse_num <= '0;
      bus.dir_out   <= '0;
      motor_q       <= '0;
      bcd_q         <= '0;
      acc           <= '0;
      bad           <= 1'b0;
      dcnt          <= '0;
      dist_q        <= '0;
      dir_q         <= 1'b0;
      for (int i = 0; i < CH; i++) pos[i] <= '0;
    end else if (init) begin
      // Drops any in-flight command silently; ready stays low for this cycle.
      state         <= IDLE;
      bus.cmd_ready <= 1'b0;
      bus.start     <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.motor_out <= '0;
      bus.pulse_num <= '0;
      bus.dir_out   <= '0;
      motor_q       <= '0;
      bcd_q         <= '0;
      acc           <= '0;
      bad           <= 1'b0;
      dcnt          <= '0;
      dist_q        <= '0;
      dir_q         <= 1'b0;
      for (int i = 0; i < CH; i++) pos[i] <= '0;
    end else begin
      state         <= state_n;
      bus.cmd_ready <= ready_n;
      bus.start     <= start_n;
      bus.done      <= done_n;
      bus.err       <= err_n;

      if (accept) begin
        motor_q <= bus.cmd_motor;
        bcd_q   <= bus.cmd_bcd;
        acc     <= '0;
        bad     <= 1'b0;
        dcnt    <= '0;
      end

      if (state == CONV) begin
        acc   <= acc_next;
        bad   <= bad | (digit > 4'd9);
        bcd_q <= bcd_q << 4;
        dcnt  <= dcnt + DCW'(1);
      end

      if (state == CHECK) begin
        dist_q <= dist_c;
        dir_q  <= (acc_pw < pos_cur);
      end

      // Only the moved channel's direction bit changes; the rest hold.
      if (do_issue) begin
        bus.motor_out       <= motor_q;
        bus.pulse_num       <= PNW'(dist_q) * PNW'(PPU);
        bus.dir_out[ch_idx] <= dir_q;
        pos[ch_idx]         <= acc_pw;
      end
    end
  end

  always_comb begin
    pos_rd = '0;
    for (int i = 0; i < CH; i++) begin
      if (CW'(i) == pos_sel) pos_rd = pos[i];
    end
  end

endmodule

// File: doc/motor_cmd_ctrl.md
# motor_cmd_ctrl

Parametrised multi-axis move controller between the command decoder and the pulse generator. It accepts one BCD absolute-target command at a time through a valid/ready handshake and converts it to binary. It checks the command against homing status and soft limits, then computes the pulse count and direction from the stored per-axis position. It issues one start strobe to the pulse generator and tracks its busy line until the move completes.

## Interface
Parameters:
- CH, 6: number of motor channels.
- DIGITS, 3: BCD digits per target.
- PW, 10: position width (binary).
- MAX_POS, 999: soft upper limit; targets above it are rejected.
- PPU, 1: pulses per position unit.
- PNW, 16: pulse-count width; must satisfy PNW ≥ width(MAX_POS*PPU).

Ports:
- sysclk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- init  in  1  synchronous clear, highest priority after rst
- home_done  in  CH  per-channel homing-complete flags
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_motor  in  CH  one-hot target channel
- cmd_bcd  in  4*DIGITS  target, most significant digit in the top nibble
- busy  in  1  pulse generator running
- start  out  1  one-cycle move strobe
- motor_out  out  CH  one-hot channel of the issued move
- pulse_num  out  PNW  pulses for the issued move
- dir_out  out  CH  per-channel direction, 1 = reverse, 0 = forward
- done  out  1  one-cycle move-complete strobe
- err  out  1  one-cycle command-rejected strobe
- pos_sel  in  $clog2(CH)  readback channel index
- pos_rd  out  PW  stored position of channel pos_sel (combinational)

## Operation
- State machine states: IDLE, CONV, CHECK, ISSUE, ACK, WAIT.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch cmd_motor and cmd_bcd, clear acc, go to CONV.
- CONV:
  - Runs DIGITS cycles, one digit per cycle, MSD first: acc ← acc*10 + digit.
  - Any digit > 9 sets the bad flag.
  - Exit to CHECK.
- CHECK, reject conditions:
  - bad flag set;
  - cmd_motor not exactly one-hot;
  - home_done of the selected channel is 0;
  - acc > MAX_POS.
- CHECK, rejected: pulse err, go to IDLE; positions, dir_out and outputs are unchanged.
- CHECK, distance zero (acc == pos[ch]): pulse done, go to IDLE; no start; dir_out[ch] is held.
- CHECK, otherwise:
  - dist = |acc − pos[ch]|;
  - dir bit = (acc < pos[ch]);
  - go to ISSUE.
- ISSUE:
  - Wait while busy=1.
  - When busy=0:
    - start=1;
    - motor_out = the one-hot channel;
    - pulse_num = dist*PPU;
    - dir_out[ch] = dir bit; other dir_out bits are held;
    - pos[ch] ← acc;
    - go to ACK.
- ACK: one cycle with busy ignored, then go to WAIT.
- WAIT: when busy=0, pulse done and go to IDLE.
- motor_out, pulse_num and dir_out hold their values between moves.
- init=1 (synchronous):
  - all positions, outputs and acc cleared;
  - state goes to IDLE, cmd_ready=0 for that cycle;
  - any in-flight command is dropped, with no done or err.
- Arithmetic is unsigned. acc is PW+4 bits wide so the overflow check is exact.

## Timing
- Reset (rst=0) forces all of the following to 0:
  - cmd_ready, start, motor_out, pulse_num, dir_out, done, err;
  - every position register.
- State goes to IDLE on reset; cmd_ready rises on the first sysclk edge after rst is released.
- All outputs are registered, except pos_rd.
- cmd_ready drops on the accept edge and is low until the controller returns to IDLE.
- Accept at edge k:
  - CONV occupies edges k+1 … k+DIGITS;
  - CHECK is evaluated at edge k+DIGITS+1;
  - err or zero-distance done is high in the cycle after edge k+DIGITS+1;
  - start is high, at the earliest, in the cycle after edge k+DIGITS+2, provided busy=0.
- The pulse generator must raise busy within one cycle of start. If busy never rises, done follows 2 cycles after start.
- done, err and start are never high together. Each is exactly one cycle wide.
- The next accept is possible one cycle after done or err.

## Test plan
- Reset, home_done=all 1, channel 0 target BCD 0x123 with busy tied low:
  - start in the cycle after edge k+5;
  - pulse_num=123, dir_out[0]=0, motor_out=000001, pos_rd=123;
  - done 2 cycles after start.
- Channel 0, then target 0x050: pulse_num=73, dir_out[0]=1. Repeat 0x050: done, no start, dir_out[0] stays 1.
- Rejects, each produces err, leaves pos unchanged and issues no start:
  - cmd_bcd=0x1A0;
  - cmd_motor=000011;
  - home_done[2]=0 with a command to channel 2;
  - MAX_POS=500 with target 0x600.
- busy held high 20 cycles before ISSUE: start is delayed until busy=0. With busy high 10 cycles after start, done comes on the cycle busy falls.
- init pulsed during WAIT: no done; all positions read 0; the next command 0x010 gives pulse_num=10, dir 0.
- PPU=4, CH=3: target 0x100 from 0 gives pulse_num=400, motor_out=001. Back-to-back commands on channels 1 and 2 keep independent positions.
